demux_reg16_32: RTL and testbench
=================================

# demux_reg16_32

Write-side counterpart of the 16-way 32-bit word selector: accepts addressed 32-bit writes over a valid/ready handshake and steers each into one of sixteen 32-bit holding registers. All sixteen registers are presented in parallel, ready to feed the 16:1 read selector. A sequenced clear command sweeps the bank to zero one word per cycle. The block sits between the bus write path and the peripheral/debug register read-out.

## Interface
Parameters:
- N_WORDS, 16, number of holding registers; fixed, sel width is 4
- WORD_W, 32, data width per register

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- wr_valid  input  1  write request present
- wr_ready  output  1  block can accept a write this cycle
- wr_sel  input  4  destination register index 0..15
- wr_data  input  32  write data
- wr_strb  input  4  byte strobes, bit i covers bits 8i+7:8i; only present with DEMUX_REG16_STRB_EN
- clr_req  input  1  start clear sweep (sampled only in IDLE)
- clr_busy  output  1  high while sweep in progress
- clr_done  output  1  one-cycle pulse on final sweep cycle
- q  output  512  flattened register bank, word i at bits 32i+31:32i
- q_vld  output  16  bit i set once word i written since last reset/clear

## Operation
- States: IDLE, CLEAR. Reset -> IDLE.
- IDLE: wr_ready = !clr_req. Write accepted when wr_valid && wr_ready; q word wr_sel updated at that edge, q_vld[wr_sel] set. Other words unchanged.
- clr_req in IDLE wins over a simultaneous write: wr_ready low that cycle, write not taken (requester holds wr_valid); next state CLEAR, sweep counter cnt = 0.
- CLEAR: each cycle zero q word cnt and clear q_vld[cnt]; cnt increments. At cnt == 15: clr_done = 1, next state IDLE, cnt wraps to 0. wr_ready = 0, clr_busy = 1 throughout CLEAR. clr_req ignored in CLEAR.
- wr_sel fully decoded; all 16 values legal, no out-of-range case.
- Handshake: wr_data/wr_sel/wr_strb need be stable only in the accepting cycle; wr_valid may drop without acceptance (no protocol penalty).

## Timing
- Reset values: q = 0, q_vld = 0, wr_ready = 0 during rst cycle then 1 (if clr_req low), clr_busy = 0, clr_done = 0, state IDLE, cnt = 0.
- Write latency: accept at edge N, new value on q and q_vld from cycle N+1. Throughput one write per cycle in IDLE.
- Clear: clr_req sampled at edge N -> clr_busy high cycles N+1..N+16; word k zeroed at the end of cycle N+1+k; clr_done high in cycle N+16; wr_ready high again cycle N+17.
- Reset mid-sweep: immediate return to IDLE, whole bank zero, no clr_done pulse.
- All outputs registered except wr_ready (combinational from state and clr_req).

## Configuration
- DEMUX_REG16_STRB_EN defined: wr_strb port exists; on accept only bytes with strobe set are written; q_vld[wr_sel] set if any strobe bit set; wr_strb = 0 is an accepted no-op.
- Undefined: no wr_strb port; every accepted write replaces the full 32-bit word.

## Structure
- Shared package: N_WORDS, WORD_W, SEL_W = 4, STRB_W = 4, state encoding constants ST_IDLE/ST_CLEAR.
- One sub-module: demux_reg16_32_dec, 4-to-16 one-hot decoder with enable; instantiated once for the write index, once for the sweep counter.
- Registers, state machine and counter live in the top module.

## Test plan
- Reset then write sel=5, data=0xDEADBEEF -> next cycle q word 5 = 0xDEADBEEF, q_vld = 0x0020, all other words 0.
- Back-to-back writes sel 0..15, data = 0x1000+i, wr_valid held -> 16 accepts in 16 cycles, q_vld = 0xFFFF, each word matches.
- clr_req and wr_valid same cycle in IDLE (sel=3) -> wr_ready low, write not taken; clr_busy 16 cycles, clr_done in cycle 16, then held write accepted; q_vld = 0x0008.
- rst asserted at sweep cycle 7 with bank full -> next cycle state IDLE, q = 0, q_vld = 0, no clr_done.
- With DEMUX_REG16_STRB_EN: word 2 = 0xAABBCCDD, write 0x11223344 strb=0b0101 -> word 2 = 0xAA22CC44; strb=0 write -> unchanged, q_vld unchanged.
- Writes attempted during CLEAR -> wr_ready 0 every sweep cycle, no register change beyond the sweep.

Source files
------------

// File: rtl/demux_reg16_32_pkg.sv
// Shared constants, state encoding and helpers for the demux_reg16_32 write-side register bank.
// Optional byte-strobe support is selected with the DEMUX_REG16_STRB_EN macro.
package demux_reg16_32_pkg;

  localparam int N_WORDS = 16;
  localparam int WORD_W  = 32;
  localparam int SEL_W   = 4;
  localparam int STRB_W  = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Expand per-byte strobes into a bit mask covering the whole word.
  function automatic logic [WORD_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
    logic [WORD_W-1:0] mask;
    mask = {WORD_W{1'b0}};
    for (int b = 0; b < STRB_W; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/demux_reg16_32_dec.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
module demux_reg16_32_dec
  import demux_reg16_32_pkg::*;
(
  input  logic               en,
  input  logic [SEL_W-1:0]   idx,
  output logic [N_WORDS-1:0] hot
);

  // Drive exactly one output high for the selected index while enabled.
  always_comb begin
    hot = {N_WORDS{1'b0}};
    if (en) begin
      hot[idx] = 1'b1;
    end else begin
      hot = {N_WORDS{1'b0}};
    end
  end

endmodule

// File: rtl/demux_reg16_32.sv
// Addressed write path into sixteen 32-bit holding registers with a
// one-word-per-cycle clear sweep. All registers are presented in parallel on q.
// Define DEMUX_REG16_STRB_EN to add the wr_strb byte-strobe port.
module demux_reg16_32
  import demux_reg16_32_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [WORD_W-1:0]          wr_data,
`ifdef DEMUX_REG16_STRB_EN
  input  logic [STRB_W-1:0]          wr_strb,
`endif
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       clr_done,
  output logic [N_WORDS*WORD_W-1:0]  q,
  output logic [N_WORDS-1:0]         q_vld
);

  state_t                           state_r;
  logic [SEL_W-1:0]                 cnt_r;
  logic                             clr_busy_r;
  logic                             clr_done_r;
  logic [N_WORDS-1:0][WORD_W-1:0]   bank_r;
  logic [N_WORDS-1:0]               vld_r;

  logic                             wr_ready_s;
  logic                             accept_s;
  logic                             sweep_en_s;
  logic [N_WORDS-1:0]               wr_hot_s;
  logic [N_WORDS-1:0]               clr_hot_s;
  logic [WORD_W-1:0]                wr_mask_s;
  logic                             vld_set_s;

  // Writes are only taken in IDLE, outside reset, and never alongside a clear request.
  always_comb begin
    wr_ready_s = 1'b0;
    if (!rst && (state_r == ST_IDLE) && !clr_req) begin
      wr_ready_s = 1'b1;
    end else begin
      wr_ready_s = 1'b0;
    end
  end

  assign accept_s   = wr_valid && wr_ready_s;
  assign sweep_en_s = (state_r == ST_CLEAR);

  // Byte mask and valid-flag update applied to the accepted write.
  always_comb begin
    wr_mask_s = {WORD_W{1'b1}};
    vld_set_s = 1'b1;
`ifdef DEMUX_REG16_STRB_EN
    wr_mask_s = strb_to_mask(wr_strb);
    if (wr_strb != {STRB_W{1'b0}}) begin
      vld_set_s = 1'b1;
    end else begin
      vld_set_s = 1'b0;
    end
`else
    wr_mask_s = {WORD_W{1'b1}};
    vld_set_s = 1'b1;
`endif
  end

  demux_reg16_32_dec u_wr_dec (
    .en  (accept_s),
    .idx (wr_sel),
    .hot (wr_hot_s)
  );

  demux_reg16_32_dec u_clr_dec (
    .en  (sweep_en_s),
    .idx (cnt_r),
    .hot (clr_hot_s)
  );

  // Sweep sequencer: IDLE <-> CLEAR with registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {SEL_W{1'b0}};
      clr_busy_r <= 1'b0;
      clr_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          clr_done_r <= 1'b0;
          cnt_r      <= {SEL_W{1'b0}};
          if (clr_req) begin
            state_r    <= ST_CLEAR;
            clr_busy_r <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
            clr_busy_r <= 1'b0;
          end
        end
        ST_CLEAR: begin
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == 4'd15) begin
            state_r    <= ST_IDLE;
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b0;
          end else begin
            state_r    <= ST_CLEAR;
            clr_busy_r <= 1'b1;
            clr_done_r <= (cnt_r == 4'd14);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= {SEL_W{1'b0}};
          clr_busy_r <= 1'b0;
          clr_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Holding registers: sweep zeroes one word per cycle, otherwise accepted writes land.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_r <= {(N_WORDS*WORD_W){1'b0}};
      vld_r  <= {N_WORDS{1'b0}};
    end else begin
      for (int i = 0; i < N_WORDS; i++) begin
        if (clr_hot_s[i]) begin
          bank_r[i] <= {WORD_W{1'b0}};
          vld_r[i]  <= 1'b0;
        end else if (wr_hot_s[i]) begin
          bank_r[i] <= (bank_r[i] & ~wr_mask_s) | (wr_data & wr_mask_s);
          vld_r[i]  <= vld_r[i] | vld_set_s;
        end else begin
          bank_r[i] <= bank_r[i];
          vld_r[i]  <= vld_r[i];
        end
      end
    end
  end

  assign wr_ready = wr_ready_s;
  assign clr_busy = clr_busy_r;
  assign clr_done = clr_done_r;
  assign q        = bank_r;
  assign q_vld    = vld_r;

endmodule

// File: tb/tb_demux_reg16_32.sv
// Self-checking bench for demux_reg16_32: a cycle-level behavioural model of the
// register bank is compared against the DUT on every falling edge, and directed
// scenarios add hand-computed literal expectations. Byte-strobe checks run when
// DEMUX_REG16_STRB_EN is defined.
module tb_demux_reg16_32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [3:0]   wr_sel = 4'd0;
  logic [31:0]  wr_data = 32'd0;
`ifdef DEMUX_REG16_STRB_EN
  logic [3:0]   wr_strb = 4'hF;
`endif
  logic         clr_req = 1'b0;
  logic         clr_busy;
  logic         clr_done;
  logic [511:0] q;
  logic [15:0]  q_vld;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: plain word array, valid mask and sweep position (-1 = not sweeping).
  logic [31:0] m_q [16];
  logic [15:0] m_vld = 16'h0000;
  int          m_pos = -1;

  demux_reg16_32 dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
`ifdef DEMUX_REG16_STRB_EN
    .wr_strb  (wr_strb),
`endif
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .q        (q),
    .q_vld    (q_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model update from the rules of operation, using inputs as seen at the edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_q[i] <= 32'd0;
      m_vld <= 16'h0000;
      m_pos <= -1;
    end else if (m_pos >= 0) begin
      m_q[m_pos]   <= 32'd0;
      m_vld[m_pos] <= 1'b0;
      m_pos        <= (m_pos == 15) ? -1 : m_pos + 1;
    end else if (clr_req) begin
      m_pos <= 0;
    end else if (wr_valid) begin
`ifdef DEMUX_REG16_STRB_EN
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) m_q[wr_sel][8*b +: 8] <= wr_data[8*b +: 8];
      if (wr_strb != 4'd0) m_vld[wr_sel] <= 1'b1;
`else
      m_q[wr_sel]   <= wr_data;
      m_vld[wr_sel] <= 1'b1;
`endif
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    logic [511:0] exp_q;
    if (chk_en) begin
      for (int i = 0; i < 16; i++) exp_q[32*i +: 32] = m_q[i];
      chk("model_q", q, exp_q);
      chk("model_q_vld", {496'd0, q_vld}, {496'd0, m_vld});
      chk("model_clr_busy", {511'd0, clr_busy}, {511'd0, (m_pos >= 0)});
      chk("model_clr_done", {511'd0, clr_done}, {511'd0, (m_pos == 15)});
      chk("model_wr_ready", {511'd0, wr_ready}, {511'd0, (!rst && m_pos < 0 && !clr_req)});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_sel   = 4'(i);
      wr_data  = base + 32'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    logic [511:0] tmp;
    int acc;
    int busy_n;
    int done_at;
    int accepted;
    int rdy_n;
    int done_seen;

    // Reset
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_q", q, 512'd0);
    chk("rst_q_vld", {496'd0, q_vld}, 512'd0);
    chk("rst_clr_busy", {511'd0, clr_busy}, 512'd0);
    chk("rst_clr_done", {511'd0, clr_done}, 512'd0);
    chk("rst_wr_ready_after", {511'd0, wr_ready}, 512'd1);

    // Single write to word 5
    wr_valid = 1'b1; wr_sel = 4'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_valid = 1'b0;
    chk("t1_word5", {480'd0, q[5*32 +: 32]}, {480'd0, 32'hDEADBEEF});
    chk("t1_q_vld", {496'd0, q_vld}, {496'd0, 16'h0020});
    tmp = q; tmp[5*32 +: 32] = 32'd0;
    chk("t1_others_zero", tmp, 512'd0);

    // Back-to-back writes to every word
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_sel = 4'(i); wr_data = 32'h1000 + 32'(i);
      if (wr_ready) acc++;
      tick();
    end
    wr_valid = 1'b0;
    chk("t2_accepts", 512'(acc), 512'd16);
    chk("t2_q_vld", {496'd0, q_vld}, {496'd0, 16'hFFFF});
    for (int i = 0; i < 16; i++)
      chk("t2_word", {480'd0, q[32*i +: 32]}, {480'd0, 32'h1000 + 32'(i)});

    // Clear request collides with a write; held write lands after the sweep
    clr_req = 1'b1; wr_valid = 1'b1; wr_sel = 4'd3; wr_data = 32'hCAFE0003;
    #1;
    chk("t3_ready_low", {511'd0, wr_ready}, 512'd0);
    tick();
    clr_req = 1'b0;
    busy_n = 0; done_at = -1; accepted = 0;
    for (int c = 1; c <= 40 && accepted == 0; c++) begin
      if (clr_busy) busy_n++;
      if (clr_done) done_at = c;
      if (wr_ready) begin
        chk("t3_ready_cycle", 512'(c), 512'd17);
        tick();
        wr_valid = 1'b0;
        accepted = 1;
      end else begin
        tick();
      end
    end
    wr_valid = 1'b0;
    chk("t3_accepted", 512'(accepted), 512'd1);
    chk("t3_busy_cycles", 512'(busy_n), 512'd16);
    chk("t3_done_cycle", 512'(done_at), 512'd16);
    chk("t3_q_vld", {496'd0, q_vld}, {496'd0, 16'h0008});
    chk("t3_word3", {480'd0, q[3*32 +: 32]}, {480'd0, 32'hCAFE0003});
    tmp = q; tmp[3*32 +: 32] = 32'd0;
    chk("t3_others_zero", tmp, 512'd0);

`ifdef DEMUX_REG16_STRB_EN
    // Byte strobes
    wr_valid = 1'b1; wr_sel = 4'd2; wr_data = 32'hAABBCCDD; wr_strb = 4'hF;
    tick();
    wr_data = 32'h11223344; wr_strb = 4'b0101;
    tick();
    wr_valid = 1'b0;
    chk("strb_merge", {480'd0, q[2*32 +: 32]}, {480'd0, 32'hAA22CC44});
    chk("strb_vld", {496'd0, q_vld}, {496'd0, 16'h000C});
    wr_valid = 1'b1; wr_data = 32'hFFFFFFFF; wr_strb = 4'b0000;
    tick();
    wr_valid = 1'b0; wr_strb = 4'hF;
    chk("strb_zero_word", {480'd0, q[2*32 +: 32]}, {480'd0, 32'hAA22CC44});
    chk("strb_zero_vld", {496'd0, q_vld}, {496'd0, 16'h000C});
`endif

    // Writes attempted during a sweep are refused
    fill(32'h7700_0000);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    rdy_n = 0;
    for (int k = 0; k < 16; k++) begin
      wr_valid = 1'b1; wr_sel = 4'(15 - k); wr_data = 32'h0BAD_0000 + 32'(k);
      if (wr_ready) rdy_n++;
      tick();
    end
    wr_valid = 1'b0;
    chk("t4_ready_during_clear", 512'(rdy_n), 512'd0);
    chk("t4_q_zero", q, 512'd0);
    chk("t4_q_vld_zero", {496'd0, q_vld}, 512'd0);

    // Reset in the middle of a sweep
    fill(32'h5000_0000);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (7) tick();
    chk("t5_vld_at_cnt7", {496'd0, q_vld}, {496'd0, 16'hFF80});
    chk("t5_word7_kept", {480'd0, q[7*32 +: 32]}, {480'd0, 32'h5000_0007});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_q_zero", q, 512'd0);
    chk("t5_q_vld_zero", {496'd0, q_vld}, 512'd0);
    chk("t5_busy_low", {511'd0, clr_busy}, 512'd0);
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (clr_done) done_seen = 1;
      tick();
    end
    chk("t5_no_done", 512'(done_seen), 512'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
